// File: rtl/cpu_run_controller_pkg.sv
// Shared definitions for the single-cycle RISC-V run controller.
//
// Contents:
//   run_state_t     - sequencer states (IDLE, CLEAR, PRELOAD, RUN, DONE)
//   OPC_SYSTEM      - ecall/ebreak opcode that ends a run
//   DEF_CLR_CYCLES  - default number of cycles the datapath reset is held
//   DEF_MAX_CYCLES  - default watchdog limit in enabled cycles (0 = off)
package cpu_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PRELOAD,
        RUN,
        DONE
    } run_state_t;

    localparam logic [6:0]  OPC_SYSTEM     = 7'h73;
    localparam int unsigned DEF_CLR_CYCLES = 2;
    localparam int unsigned DEF_MAX_CYCLES = 1000000;

endpackage

// File: rtl/cpu_run_controller_btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a raw board button.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low reset
//   btn    in   raw button level, asynchronous to clk
//   evt    out  registered one-cycle pulse, three clocks after the button rises
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // sync1/sync2 resolve metastability; sync2_d holds the previous clean
    // level so a rising edge yields exactly one pulse however long the
    // button is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            evt     <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
            evt     <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Top-level sequencer for the single-cycle RISC-V datapath.
// Latches the switch operand, holds the datapath in reset, pulses the RAM
// preload, runs the program until a SYSTEM opcode or the watchdog, and
// latches RAM[1] as the displayed result.
//
// Optional build macro RUN_CTRL_STEP_EN adds single-step ports.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   start_btn    in   raw start button
//   abort        in   synchronous abort back to IDLE
//   n_sw         in   operand switches (zero-extended to 32 bits)
//   opcode       in   current instruction opcode
//   ram_word1    in   RAM[1] tap from the datapath
//   step_mode    in   (RUN_CTRL_STEP_EN) 1 = single-step
//   step_btn     in   (RUN_CTRL_STEP_EN) raw step button
//   cpu_reset    out  active-high datapath reset
//   started      out  one-cycle RAM preload strobe
//   n_escolhido  out  latched operand
//   cpu_en       out  gate for PC update, RegWrite and MemWrite
//   busy         out  high in CLEAR/PRELOAD/RUN
//   done         out  high in DONE
//   timeout      out  last run ended by the watchdog
//   result       out  RAM[1] captured at the end of the last run
//   instr_count  out  instructions committed in the last/current run
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int unsigned N_WIDTH     = 8,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int unsigned CLR_CYCLES  = DEF_CLR_CYCLES,
    parameter logic [6:0]  HALT_OPCODE = OPC_SYSTEM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_btn,
    input  logic                 abort,
    input  logic [N_WIDTH-1:0]   n_sw,
    input  logic [6:0]           opcode,
    input  logic [31:0]          ram_word1,
`ifdef RUN_CTRL_STEP_EN
    input  logic                 step_mode,
    input  logic                 step_btn,
`endif
    output logic                 cpu_reset,
    output logic                 started,
    output logic [31:0]          n_escolhido,
    output logic                 cpu_en,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [31:0]          result,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [31:0]          CLR_LAST = 32'(CLR_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam bit                   WD_EN    = (MAX_CYCLES != 0);

    run_state_t  state;
    run_state_t  state_next;
    logic [31:0] clr_cnt;
    logic        start_evt;
    logic        step_ok;
    logic        halt_hit;
    logic        wd_hit;
    logic        launch;

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (start_btn),
        .evt   (start_evt)
    );

`ifdef RUN_CTRL_STEP_EN
    logic step_evt;
    logic step_pend;

    btn_sync_edge u_step_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .evt   (step_evt)
    );

    // Delays each step event by one clock so cpu_en opens for exactly the
    // cycle that follows the event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_pend <= 1'b0;
        end else begin
            step_pend <= step_evt;
        end
    end

    assign step_ok = !step_mode || step_pend;
`else
    assign step_ok = 1'b1;
`endif

    // The halt opcode is decoded combinationally so it never commits; in
    // step mode both halt and watchdog only look at enabled cycles.
    assign halt_hit = (state == RUN) && step_ok && (opcode == HALT_OPCODE);
    assign cpu_en   = (state == RUN) && step_ok && (opcode != HALT_OPCODE);
    assign wd_hit   = WD_EN && cpu_en && (instr_count == WD_LAST);

    assign cpu_reset = (state == IDLE) || (state == CLEAR);
    assign started   = (state == PRELOAD);
    assign busy      = (state == CLEAR) || (state == PRELOAD) || (state == RUN);
    assign done      = (state == DONE);

    // A new run may only be launched from a resting state, and an abort
    // taken in DONE overrides a simultaneous start.
    assign launch = start_evt && ((state == IDLE) || ((state == DONE) && !abort));

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_evt) state_next = CLEAR;
            CLEAR:   if (clr_cnt == CLR_LAST) state_next = PRELOAD;
            PRELOAD: state_next = RUN;
            RUN:     if (halt_hit || wd_hit) state_next = DONE;
            DONE:    if (start_evt) state_next = CLEAR;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // State register, CLEAR dwell counter and the run bookkeeping. An
    // abort leaves result, instr_count and timeout exactly as they were.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            n_escolhido <= '0;
            result      <= '0;
            instr_count <= '0;
            timeout     <= 1'b0;
        end else begin
            state   <= state_next;
            clr_cnt <= (state == CLEAR) ? clr_cnt + 32'd1 : '0;
            if (launch) begin
                n_escolhido <= 32'(n_sw);
                instr_count <= '0;
                timeout     <= 1'b0;
            end else if ((state == RUN) && !abort) begin
                if (cpu_en && (instr_count != '1)) begin
                    instr_count <= instr_count + CNT_WIDTH'(1);
                end
                if (halt_hit) begin
                    result <= ram_word1;
                end else if (wd_hit) begin
                    result  <= ram_word1;
                    timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller, built with a
// 16-cycle watchdog and the default 2-cycle CLEAR dwell.
// Covers reset, start latency, CLEAR/PRELOAD timing, halt, watchdog,
// halt/watchdog coincidence, abort, ignored starts and (with
// RUN_CTRL_STEP_EN) single-stepping.
module tb_cpu_run_controller;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        start_btn = 1'b0;
    logic        abort     = 1'b0;
    logic [7:0]  n_sw      = '0;
    logic [6:0]  opcode    = 7'h13;
    logic [31:0] ram_word1 = '0;
`ifdef RUN_CTRL_STEP_EN
    logic        step_mode = 1'b0;
    logic        step_btn  = 1'b0;
`endif

    logic        cpu_reset;
    logic        started;
    logic [31:0] n_escolhido;
    logic        cpu_en;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] result;
    logic [31:0] instr_count;

    int check_count = 0;
    int pass_count  = 0;

    cpu_run_controller #(
        .N_WIDTH     (8),
        .CNT_WIDTH   (32),
        .MAX_CYCLES  (16),
        .CLR_CYCLES  (2),
        .HALT_OPCODE (7'h73)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .abort       (abort),
        .n_sw        (n_sw),
        .opcode      (opcode),
        .ram_word1   (ram_word1),
`ifdef RUN_CTRL_STEP_EN
        .step_mode   (step_mode),
        .step_btn    (step_btn),
`endif
        .cpu_reset   (cpu_reset),
        .started     (started),
        .n_escolhido (n_escolhido),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .result      (result),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] n, input logic [6:0] op,
                                 input logic [31:0] ram);
        n_sw      = n;
        opcode    = op;
        ram_word1 = ram;
        #1;
    endtask

    // Presses start and returns while the PRELOAD cycle is being sampled.
    task automatic startRun(input string tag);
        bit seen;
        seen = 1'b0;
        start_btn = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (started) seen = 1'b1;
        end
        start_btn = 1'b0;
        checkOutput({tag, "_preload_reached"}, 64'(seen), 64'd1);
    endtask

    initial begin
        bit          stray;
        bit          seen;
        bit          all_en;
        int          en_cycles;

        // Reset asserted: every output at its reset value.
        repeat (3) tick();
        checkOutput("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        checkOutput("rst_busy_done_en_started", 64'({busy, done, cpu_en, started, timeout}), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_count_n", 64'({instr_count, n_escolhido}), 64'd0);

        // Released, no button: idle for 100 cycles.
        reset = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy || !cpu_reset || done || cpu_en || result != 0) stray = 1'b1;
        end
        checkOutput("idle_100_cycles_stray", 64'(stray), 64'd0);

        // Start with n=5; nothing visible during the first two synchronizer clocks.
        applyStimulus(8'd5, 7'h13, 32'd0);
        start_btn = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (busy) stray = 1'b1;
        end
        checkOutput("start_not_early", 64'(stray), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (busy) seen = 1'b1;
        end
        checkOutput("start_reached_clear", 64'(seen), 64'd1);
        checkOutput("clear1_outputs", 64'({cpu_reset, started, cpu_en}), 64'b100);
        checkOutput("n_latched_5", 64'(n_escolhido), 64'd5);
        tick();
        checkOutput("clear2_outputs", 64'({cpu_reset, started, busy}), 64'b101);
        tick();
        checkOutput("preload_outputs", 64'({cpu_reset, started, busy, cpu_en}), 64'b0110);
        tick();
        checkOutput("run0_outputs", 64'({cpu_reset, started, busy, cpu_en}), 64'b0011);

        // Ten committed instructions; a fresh start press mid-run is ignored.
        all_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) start_btn = 1'b0;
            if (k == 4) start_btn = 1'b1;
            if (!cpu_en || !busy) all_en = 1'b0;
            tick();
        end
        checkOutput("run_all_enabled", 64'(all_en), 64'd1);
        checkOutput("run_count_10", 64'(instr_count), 64'd10);
        applyStimulus(8'd5, 7'h73, 32'd120);
        checkOutput("halt_cpu_en_low", 64'(cpu_en), 64'd0);
        checkOutput("halt_not_done_yet", 64'(done), 64'd0);
        tick();
        checkOutput("halt_done", 64'({done, busy, cpu_reset, cpu_en}), 64'b1000);
        checkOutput("halt_result", 64'(result), 64'd120);
        checkOutput("halt_count", 64'(instr_count), 64'd10);
        checkOutput("halt_timeout", 64'(timeout), 64'd0);
        repeat (3) tick();
        checkOutput("done_holds", 64'({done, result}), {31'd0, 1'b1, 32'd120});

        // Watchdog run from DONE: 16 enabled cycles then timeout.
        start_btn = 1'b0;
        repeat (3) tick();
        applyStimulus(8'hA7, 7'h13, 32'hDEAD_BEEF);
        startRun("wd");
        checkOutput("wd_n_latched", 64'(n_escolhido), 64'hA7);
        checkOutput("wd_count_cleared", 64'(instr_count), 64'd0);
        checkOutput("wd_result_held", 64'(result), 64'd120);
        tick();
        en_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (cpu_en) en_cycles++;
                tick();
            end
        end
        checkOutput("wd_done_reached", 64'(seen), 64'd1);
        checkOutput("wd_enabled_cycles", 64'(en_cycles), 64'd16);
        checkOutput("wd_count_16", 64'(instr_count), 64'd16);
        checkOutput("wd_timeout", 64'(timeout), 64'd1);
        checkOutput("wd_result", 64'(result), 64'hDEAD_BEEF);

        // Abort in RUN cycle 4: back to IDLE with bookkeeping held.
        applyStimulus(8'd3, 7'h13, 32'h1111_2222);
        startRun("abort");
        tick();
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_idle", 64'({busy, done, cpu_reset, cpu_en}), 64'b0010);
        checkOutput("abort_count_held", 64'(instr_count), 64'd4);
        checkOutput("abort_result_held", 64'(result), 64'hDEAD_BEEF);
        checkOutput("abort_timeout_held", 64'(timeout), 64'd0);
        repeat (5) tick();
        checkOutput("abort_stays_idle", 64'({busy, cpu_reset}), 64'b01);

        // Halt on the cycle the watchdog would fire: halt wins.
        applyStimulus(8'd9, 7'h13, 32'h55);
        repeat (3) tick();
        startRun("coinc");
        checkOutput("coinc_n_latched", 64'(n_escolhido), 64'd9);
        tick();
        repeat (15) tick();
        checkOutput("coinc_count_15", 64'(instr_count), 64'd15);
        applyStimulus(8'd9, 7'h73, 32'h55);
        tick();
        checkOutput("coinc_done", 64'(done), 64'd1);
        checkOutput("coinc_timeout", 64'(timeout), 64'd0);
        checkOutput("coinc_count", 64'(instr_count), 64'd15);
        checkOutput("coinc_result", 64'(result), 64'h55);

`ifdef RUN_CTRL_STEP_EN
        // Single-step: three presses give exactly three enabled cycles.
        applyStimulus(8'd1, 7'h13, 32'h77);
        step_mode = 1'b1;
        repeat (3) tick();
        startRun("step");
        tick();
        en_cycles = 0;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 6; c++) begin
                step_btn = (c < 2);
                if (cpu_en) en_cycles++;
                tick();
            end
        end
        for (int c = 0; c < 6; c++) begin
            if (cpu_en) en_cycles++;
            tick();
        end
        checkOutput("step_pulses", 64'(en_cycles), 64'd3);
        checkOutput("step_count", 64'(instr_count), 64'd3);
        applyStimulus(8'd1, 7'h73, 32'h77);
        repeat (5) tick();
        checkOutput("step_halt_waits", 64'(done), 64'd0);
        step_btn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        step_btn = 1'b0;
        checkOutput("step_halt_done", 64'(seen), 64'd1);
        checkOutput("step_halt_result", 64'({result, instr_count}), {32'h77, 32'd3});
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Top-level sequencer for the single-cycle RISC-V datapath.
- Takes the operand n from board switches and a start button, then holds the datapath in reset and pulses the RAM preload.
- Runs the program with a gated enable until a SYSTEM (ecall/ebreak) opcode is fetched or a watchdog expires.
- Latches the RAM[1] word as the displayed result. Sits between board I/O and the datapath/control unit.

Parameters:
- N_WIDTH, 8: width of switch operand n; zero-extended to 32 bits.
- CNT_WIDTH, 32: width of the executed-instruction counter.
- MAX_CYCLES, 1000000: watchdog limit in enabled cycles; 0 disables the watchdog.
- CLR_CYCLES, 2: number of cycles the datapath reset is held in CLEAR (≥1).
- HALT_OPCODE, 7'h73: opcode that terminates a run.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_btn  in  1  raw start button, asynchronous to clk.
- abort  in  1  synchronous abort; returns to IDLE.
- n_sw  in  N_WIDTH  operand switches.
- opcode  in  7  current instruction opcode from datapath.
- ram_word1  in  32  RAM[1] tap from datapath.
- cpu_reset  out  1  active-high reset to datapath/PC.
- started  out  1  preload strobe to data memory.
- n_escolhido  out  32  latched operand.
- cpu_en  out  1  gate for PC update, RegWrite and MemWrite.
- busy  out  1  high in CLEAR/PRELOAD/RUN.
- done  out  1  high in DONE.
- timeout  out  1  run ended by watchdog.
- result  out  32  latched RAM[1] at end of run.
- instr_count  out  CNT_WIDTH  instructions executed in last/current run.

Behaviour:
- Reset (reset=0, async): state=IDLE, cpu_reset=1, started=0, n_escolhido=0, result=0, instr_count=0, timeout=0, done=0, busy=0, cpu_en=0. Synchronizer flops are cleared.
- start_btn passes through a 2-flop synchronizer and a rising-edge detector. start_evt is a 1-cycle pulse, with 3 cycles latency from the button edge.
- FSM states: IDLE, CLEAR, PRELOAD, RUN, DONE.
  - IDLE: cpu_reset=1. On start_evt: n_escolhido<=zero-extended n_sw, instr_count<=0, timeout<=0, go to CLEAR.
  - CLEAR: cpu_reset=1 for exactly CLR_CYCLES cycles (internal counter), then go to PRELOAD.
  - PRELOAD: cpu_reset=0, started=1 for exactly one cycle, then go to RUN.
  - RUN: cpu_en = (state==RUN) && (opcode!=HALT_OPCODE). This is combinational, so the halt instruction itself never commits. instr_count increments on every cycle with cpu_en=1.
    - If opcode==HALT_OPCODE: result<=ram_word1, go to DONE.
    - Else if MAX_CYCLES!=0 and instr_count==MAX_CYCLES-1 with cpu_en=1: result<=ram_word1, timeout<=1, go to DONE. That final instruction does commit.
    - If halt and watchdog coincide, halt wins and timeout=0.
  - DONE: done=1, cpu_en=0, cpu_reset=0, so the datapath is frozen and still readable. On start_evt go to CLEAR with a new n latched, and clear instr_count and timeout. result holds until the next run ends.
- abort=1 in any non-IDLE state: next state IDLE. result, instr_count and timeout hold their values. abort has priority over all other transitions.
- start_evt in CLEAR/PRELOAD/RUN is ignored.
- instr_count saturates at all-ones; it never wraps.
- Outputs other than cpu_en are registered or decoded from state only.

Optional Feature:
- Macro: RUN_CTRL_STEP_EN.
- When defined:
  - Adds input ports step_mode (1) and step_btn (1). step_btn is synchronized and edge-detected the same way as start_btn.
  - In RUN with step_mode=1, cpu_en is asserted only in the single cycle following each step event.
  - Halt and watchdog are evaluated only on enabled cycles.
  - step_mode=0 gives free-running behaviour.
- When undefined: no extra ports, and RUN is always free-running.

Decomposition:
- Package cpu_run_pkg: state enum (IDLE, CLEAR, PRELOAD, RUN, DONE), OPC_SYSTEM=7'h73 constant, default CLR_CYCLES/MAX_CYCLES constants.
- Sub-module btn_sync_edge (2-flop sync + rising-edge pulse), instantiated once for start_btn and once for step_btn.

Test Plan:
- Reset release, no button → IDLE, cpu_reset=1, result=0, busy=0 held for 100 cycles.
- n_sw=8'd5, start pulse → 3 cycles later CLEAR for 2 cycles, started=1 exactly 1 cycle, then RUN. n_escolhido=32'd5.
- RUN with opcode non-SYSTEM for 10 cycles, then 7'h73 while ram_word1=32'd120 → cpu_en low that cycle, done=1 next cycle, result=120, instr_count=10, timeout=0.
- MAX_CYCLES=16 with opcode never SYSTEM → DONE after 16 enabled cycles, timeout=1, instr_count=16.
- abort asserted at RUN cycle 4 → IDLE next cycle, cpu_reset=1. Second start, and start pulses during RUN, are ignored until DONE/IDLE.
- RUN_CTRL_STEP_EN, step_mode=1, 3 step presses → exactly 3 cpu_en pulses, instr_count=3.
